// File: rtl/rw_xact_pkg.sv
// Shared types and constants for the host-side read/write transaction sequencer.
package rw_xact_pkg;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        IN_TOK   = 3'd1,
        OUT_TOK  = 3'd2,
        OUT_DATA = 3'd3,
        IN_DATA  = 3'd4
    } msg_t;

    typedef enum logic [2:0] {
        IDLE,
        TOK_A,
        ADDR,
        TOK_D,
        DATA,
        RETRY
    } state_t;

    // Message sizes on the wire, in bits.
    localparam int unsigned DATA_SIZE   = 80;
    localparam int unsigned TOKEN_SIZE  = 27;
    localparam int unsigned HSHAKE_SIZE = 16;

endpackage

// File: rtl/rw_xact_seq_reg.sv
// Parametrised load/clear register with asynchronous active-low reset.
module rw_xact_seq_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rw_xact_seq.sv
// Turns one read/write request into the OUT token / page / IN-OUT token / data
// message sequence, retrying the whole transaction on timeout.
module rw_xact_seq
    import rw_xact_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned CNT_W     = $clog2(MAX_RETRY + 2)
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic [ADDR_W-1:0] mem_page,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start_read,
    input  logic              start_write,
    input  logic              abort,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              success,
    output logic              busy,
    output logic [CNT_W-1:0]  attempts,
    input  logic              proto_free,
    input  logic              timeout,
    input  logic [DATA_W-1:0] proto_din,
    output logic [2:0]        msg_type,
    output logic [DATA_W-1:0] msg_dout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] ALL_CNT = CNT_W'(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_attempts, w_attempts_nxt;
    logic              r_is_read, w_is_read_nxt;
    logic              w_latch;
    logic              w_rd_ld;
    logic              w_retry;
    msg_t              w_msg;
    logic [ADDR_W-1:0] r_page;
    logic [DATA_W-1:0] r_wdata;

    rw_xact_seq_reg #(.W(ADDR_W)) u_page_reg (
        .clk   (clk),
        .rst_n (rst_L),
        .ld    (w_latch),
        .clr   (1'b0),
        .d     (mem_page),
        .q     (r_page)
    );

    rw_xact_seq_reg #(.W(DATA_W)) u_wdata_reg (
        .clk   (clk),
        .rst_n (rst_L),
        .ld    (w_latch),
        .clr   (1'b0),
        .d     (wr_data),
        .q     (r_wdata)
    );

    rw_xact_seq_reg #(.W(DATA_W)) u_rdata_reg (
        .clk   (clk),
        .rst_n (rst_L),
        .ld    (w_rd_ld),
        .clr   (1'b0),
        .d     (proto_din),
        .q     (rd_data)
    );

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_attempts <= '0;
            r_is_read  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_attempts <= w_attempts_nxt;
            r_is_read  <= w_is_read_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_attempts_nxt = r_attempts;
        w_is_read_nxt  = r_is_read;
        w_latch        = 1'b0;
        w_rd_ld        = 1'b0;
        w_retry        = 1'b0;
        w_msg          = NONE;
        msg_dout       = '0;
        done           = 1'b0;
        success        = 1'b0;
        busy           = (r_state != IDLE);

        // Abort outranks timeout and proto_free; nothing is issued that cycle.
        if (r_state != IDLE && abort) begin
            done           = 1'b1;
            w_attempts_nxt = r_cnt + ONE_CNT;
            w_state_nxt    = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (proto_free && (start_read || start_write)) begin
                        w_latch       = 1'b1;
                        w_is_read_nxt = start_read;
                        w_cnt_nxt     = '0;
                        w_msg         = OUT_TOK;
                        w_state_nxt   = TOK_A;
                    end
                end
                TOK_A: begin
                    if (proto_free) begin
                        w_msg       = OUT_DATA;
                        msg_dout    = DATA_W'(r_page);
                        w_state_nxt = ADDR;
                    end
                end
                ADDR: begin
                    if (timeout) begin
                        w_retry = 1'b1;
                    end else if (proto_free) begin
                        w_msg       = r_is_read ? IN_TOK : OUT_TOK;
                        w_state_nxt = TOK_D;
                    end
                end
                TOK_D: begin
                    if (proto_free) begin
                        if (r_is_read) begin
                            w_msg = IN_DATA;
                        end else begin
                            w_msg    = OUT_DATA;
                            msg_dout = r_wdata;
                        end
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (timeout) begin
                        w_retry = 1'b1;
                    end else if (proto_free) begin
                        done           = 1'b1;
                        success        = 1'b1;
                        w_attempts_nxt = r_cnt + ONE_CNT;
                        w_rd_ld        = r_is_read;
                        w_state_nxt    = IDLE;
                    end
                end
                RETRY: begin
                    if (proto_free) begin
                        w_msg       = OUT_TOK;
                        w_state_nxt = TOK_A;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase

            if (w_retry) begin
                if (r_cnt < MAX_CNT) begin
                    w_cnt_nxt   = r_cnt + ONE_CNT;
                    w_state_nxt = RETRY;
                end else begin
                    done           = 1'b1;
                    w_attempts_nxt = ALL_CNT;
                    w_state_nxt    = IDLE;
                end
            end
        end
    end

    assign msg_type = w_msg;
    assign attempts = r_attempts;

endmodule

// File: tb/tb_rw_xact_seq.sv
// Directed bench for rw_xact_seq: inputs change after the falling edge and
// outputs are sampled 2 ns later, well before the next rising edge.
module tb_rw_xact_seq;
    import rw_xact_pkg::*;

    logic        clk;
    logic        rst_L;
    logic [15:0] mem_page;
    logic [63:0] wr_data;
    logic        start_read;
    logic        start_write;
    logic        abort;
    logic [63:0] rd_data;
    logic        done;
    logic        success;
    logic        busy;
    logic [2:0]  attempts;
    logic        proto_free;
    logic        timeout;
    logic [63:0] proto_din;
    logic [2:0]  msg_type;
    logic [63:0] msg_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_msg    = 0;
    int n_tok    = 0;

    rw_xact_seq u_dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .mem_page    (mem_page),
        .wr_data     (wr_data),
        .start_read  (start_read),
        .start_write (start_write),
        .abort       (abort),
        .rd_data     (rd_data),
        .done        (done),
        .success     (success),
        .busy        (busy),
        .attempts    (attempts),
        .proto_free  (proto_free),
        .timeout     (timeout),
        .proto_din   (proto_din),
        .msg_type    (msg_type),
        .msg_dout    (msg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts messages actually accepted by the protocol side.
    always @(posedge clk) begin
        if (proto_free && msg_type != 3'd0) n_msg <= n_msg + 1;
        if (proto_free && msg_type == 3'd2) n_tok <= n_tok + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_xact(input logic rd, input logic wr, input logic [15:0] pg,
                              input logic [63:0] wd);
        mem_page    = pg;
        wr_data     = wd;
        start_read  = rd;
        start_write = wr;
        proto_free  = 1'b1;
        #2;
        check("start_msg", 64'(msg_type), 64'(OUT_TOK));
        check("start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start_read  = 1'b0;
        start_write = 1'b0;
        proto_free  = 1'b0;
        wr_data     = '0;
        mem_page    = '0;
        #2;
        check("busy_after_start", 64'(busy), 64'd1);
        check("quiet_msg", 64'(msg_type), 64'(NONE));
        @(negedge clk);
    endtask

    task automatic issue(input string tag, input msg_t exp_msg, input logic [63:0] exp_dout);
        proto_free = 1'b1;
        #2;
        check({tag, "_msg"}, 64'(msg_type), 64'(exp_msg));
        check({tag, "_dout"}, msg_dout, exp_dout);
        @(negedge clk);
        proto_free = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_ok(input string tag, input logic [63:0] din, input logic [2:0] exp_att);
        proto_free = 1'b1;
        proto_din  = din;
        #2;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_success"}, 64'(success), 64'd1);
        @(negedge clk);
        proto_free = 1'b0;
        #2;
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_attempts"}, 64'(attempts), 64'(exp_att));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int msg_before;
        int tok_before;

        rst_L       = 1'b0;
        mem_page    = '0;
        wr_data     = '0;
        start_read  = 1'b0;
        start_write = 1'b0;
        abort       = 1'b0;
        proto_free  = 1'b0;
        timeout     = 1'b0;
        proto_din   = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd", rd_data, 64'd0);
        check("rst_att", 64'(attempts), 64'd0);
        check("rst_msg", 64'(msg_type), 64'(NONE));
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);

        // Plain read.
        start_xact(1'b1, 1'b0, 16'h0042, 64'h0);
        issue("rd_page", OUT_DATA, 64'h42);
        issue("rd_intok", IN_TOK, 64'h0);
        issue("rd_indata", IN_DATA, 64'h0);
        finish_ok("rd", 64'hDEADBEEF_01234567, 3'd1);
        check("rd_data", rd_data, 64'hDEADBEEF_01234567);

        // Plain write; the live wr_data is zeroed right after start.
        start_xact(1'b0, 1'b1, 16'h0010, 64'hA5A5_5A5A_0F0F_F0F0);
        issue("wr_page", OUT_DATA, 64'h10);
        issue("wr_outtok", OUT_TOK, 64'h0);
        issue("wr_outdata", OUT_DATA, 64'hA5A5_5A5A_0F0F_F0F0);
        finish_ok("wr", 64'h1111, 3'd1);
        check("wr_keeps_rd", rd_data, 64'hDEADBEEF_01234567);

        // One timeout in DATA, then a clean second attempt.
        start_xact(1'b1, 1'b0, 16'h0003, 64'h0);
        issue("r1_page", OUT_DATA, 64'h3);
        issue("r1_intok", IN_TOK, 64'h0);
        issue("r1_indata", IN_DATA, 64'h0);
        timeout = 1'b1;
        #2;
        check("r1_to_done", 64'(done), 64'd0);
        @(negedge clk);
        timeout = 1'b0;
        issue("r1_retok", OUT_TOK, 64'h0);
        issue("r1_page2", OUT_DATA, 64'h3);
        issue("r1_intok2", IN_TOK, 64'h0);
        issue("r1_indata2", IN_DATA, 64'h0);
        finish_ok("r1", 64'hCAFE_0000_BABE_0001, 3'd2);
        check("r1_rd", rd_data, 64'hCAFE_0000_BABE_0001);

        // Timeout in ADDR on every attempt; first one collides with proto_free.
        tok_before = n_tok;
        start_xact(1'b1, 1'b0, 16'h0007, 64'h0);
        for (int a = 0; a < 4; a++) begin
            issue("ex_page", OUT_DATA, 64'h7);
            timeout    = 1'b1;
            proto_free = (a == 0);
            #2;
            check("ex_to_msg", 64'(msg_type), 64'(NONE));
            check("ex_to_done", 64'(done), (a == 3) ? 64'd1 : 64'd0);
            check("ex_to_success", 64'(success), 64'd0);
            @(negedge clk);
            timeout    = 1'b0;
            proto_free = 1'b0;
            if (a < 3) issue("ex_retok", OUT_TOK, 64'h0);
        end
        #2;
        check("ex_tok_count", 64'(n_tok - tok_before), 64'd4);
        check("ex_attempts", 64'(attempts), 64'd4);
        check("ex_idle", 64'(busy), 64'd0);
        check("ex_rd_keep", rd_data, 64'hCAFE_0000_BABE_0001);
        @(negedge clk);

        // Abort in TOK_D.
        start_xact(1'b0, 1'b1, 16'h0020, 64'h55);
        issue("ab_page", OUT_DATA, 64'h20);
        issue("ab_outtok", OUT_TOK, 64'h0);
        msg_before = n_msg;
        abort      = 1'b1;
        proto_free = 1'b1;
        #2;
        check("ab_done", 64'(done), 64'd1);
        check("ab_success", 64'(success), 64'd0);
        check("ab_msg", 64'(msg_type), 64'(NONE));
        @(negedge clk);
        abort = 1'b0;
        #2;
        check("ab_idle", 64'(busy), 64'd0);
        check("ab_attempts", 64'(attempts), 64'd1);
        @(negedge clk);
        proto_free = 1'b0;
        #2;
        check("ab_no_issue", 64'(n_msg - msg_before), 64'd0);
        @(negedge clk);

        // Both starts together: read wins.
        start_xact(1'b1, 1'b1, 16'h0009, 64'h77);
        issue("both_page", OUT_DATA, 64'h9);
        issue("both_intok", IN_TOK, 64'h0);
        issue("both_indata", IN_DATA, 64'h0);
        finish_ok("both", 64'h0123_4567_89AB_CDEF, 3'd1);
        check("both_rd", rd_data, 64'h0123_4567_89AB_CDEF);

        // Reset while in DATA.
        start_xact(1'b1, 1'b0, 16'h0005, 64'h0);
        issue("rs_page", OUT_DATA, 64'h5);
        issue("rs_intok", IN_TOK, 64'h0);
        issue("rs_indata", IN_DATA, 64'h0);
        rst_L = 1'b0;
        #2;
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_rd", rd_data, 64'd0);
        check("rs_att", 64'(attempts), 64'd0);
        check("rs_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        start_xact(1'b0, 1'b1, 16'h0011, 64'hFEED_F00D_0000_0001);
        issue("rs_wpage", OUT_DATA, 64'h11);
        issue("rs_wtok", OUT_TOK, 64'h0);
        issue("rs_wdata", OUT_DATA, 64'hFEED_F00D_0000_0001);
        finish_ok("rs_wr", 64'h0, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
